// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, timing counts and bus widths
package sdram_pkg;

  localparam int BANK_W = 2;
  localparam int ADDR_W = 13;
  localparam int CMD_W  = 4;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b1000;
  localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;

  localparam int CNT_TRP_DEF  = 2;
  localparam int CNT_TRFC_DEF = 7;
  localparam int CNT_MRD_DEF  = 2;

  localparam logic [BANK_W-1:0] BANK_ALL = 2'b11;
  localparam logic [ADDR_W-1:0] ADDR_ALL = 13'h1fff;

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    PRE_CHARG = 6'b000010,
    WAIT_TRP  = 6'b000100,
    AUTO_REF  = 6'b001000,
    WAIT_TRFC = 6'b010000,
    AREF_END  = 6'b100000
  } aref_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// rtl/sdram_ref_timer.sv - refresh interval counter and sticky refresh request
module sdram_ref_timer #(
  parameter int CNT_REF = 749
) (
  input  logic clk,
  input  logic rst,
  input  logic init_end,
  input  logic grant,
  output logic aref_req
);

  localparam int CW = $clog2(CNT_REF + 1);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc = (cnt == CW'(CNT_REF));

  // A terminal count wins over a same-cycle grant so no refresh interval is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      aref_req <= 1'b0;
    end else begin
      if (!init_end || tc)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      if (!init_end)
        aref_req <= 1'b0;
      else if (tc)
        aref_req <= 1'b1;
      else if (grant)
        aref_req <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_aref.sv
// rtl/sdram_aref.sv - periodic auto-refresh engine: PRECHARGE-ALL then AREF_NUM AUTO-REFRESH
module sdram_aref
  import sdram_pkg::*;
#(
  parameter int CNT_REF  = 749,
  parameter int CNT_TRP  = CNT_TRP_DEF,
  parameter int CNT_TRFC = CNT_TRFC_DEF,
  parameter int AREF_NUM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic        aref_end,
  output logic [3:0]  aref_cmd,
  output logic [1:0]  aref_bank_addr,
  output logic [12:0] aref_addr
);

  aref_state_t state;
  logic [2:0]  wait_cnt;
  logic [2:0]  aref_cnt;
  logic        grant;

  assign grant          = (state == IDLE) && aref_req && aref_en;
  assign aref_end       = (state == AREF_END);
  assign aref_bank_addr = BANK_ALL;
  assign aref_addr      = ADDR_ALL;

  sdram_ref_timer #(.CNT_REF(CNT_REF)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .init_end (init_end),
    .grant    (grant),
    .aref_req (aref_req)
  );

  // Wait counter only advances in the two wait states; everywhere else it idles at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      aref_cnt <= 3'd0;
      aref_cmd <= CMD_NOP;
    end else begin
      aref_cmd <= CMD_NOP;
      wait_cnt <= 3'd0;
      case (state)
        IDLE: begin
          if (grant)
            state <= PRE_CHARG;
        end
        PRE_CHARG: begin
          aref_cmd <= CMD_PRE;
          state    <= WAIT_TRP;
        end
        WAIT_TRP: begin
          if (wait_cnt == 3'(CNT_TRP))
            state <= AUTO_REF;
          else
            wait_cnt <= wait_cnt + 3'd1;
        end
        AUTO_REF: begin
          aref_cmd <= CMD_AREF;
          state    <= WAIT_TRFC;
        end
        WAIT_TRFC: begin
          if (wait_cnt == 3'(CNT_TRFC)) begin
            aref_cnt <= aref_cnt + 3'd1;
            state    <= ((aref_cnt + 3'd1) == 3'(AREF_NUM)) ? AREF_END : AUTO_REF;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        AREF_END: begin
          aref_cnt <= 3'd0;
          state    <= IDLE;
        end
        default: begin
          aref_cnt <= 3'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_aref.sv
// tb/tb_sdram_aref.sv - self-checking bench for sdram_aref
module tb_sdram_aref;
  import sdram_pkg::*;

  localparam int CNT_REF    = 749;
  localparam int CNT_TRP    = 2;
  localparam int CNT_TRFC   = 7;
  localparam int AREF_NUM   = 2;
  localparam int P          = CNT_REF + 1;
  localparam int FIRST_AREF = 2 + (CNT_TRP + 1) + 1;
  localparam int AREF_GAP   = CNT_TRFC + 2;
  localparam int END_OFF    = 2 + (CNT_TRP + 1) + AREF_NUM * AREF_GAP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_end = 1'b0;
  logic        aref_en = 1'b0;
  logic        aref_req, aref_end;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_bank_addr;
  logic [12:0] aref_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_aref #(.CNT_REF(CNT_REF), .CNT_TRP(CNT_TRP), .CNT_TRFC(CNT_TRFC), .AREF_NUM(AREF_NUM)) dut (
    .clk            (clk),
    .rst            (rst),
    .init_end       (init_end),
    .aref_en        (aref_en),
    .aref_req       (aref_req),
    .aref_end       (aref_end),
    .aref_cmd       (aref_cmd),
    .aref_bank_addr (aref_bank_addr),
    .aref_addr      (aref_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Command expected k cycles after the grant edge, from the burst timing rules.
  function automatic logic [3:0] exp_cmd(input int k);
    if (k == 2) return CMD_PRE;
    for (int i = 0; i < AREF_NUM; i++)
      if (k == FIRST_AREF + i * AREF_GAP) return CMD_AREF;
    return CMD_NOP;
  endfunction

  // Reference model: edges since enable, request flag, and position inside a burst.
  int m_n, m_k;
  bit m_req, m_busy;
  logic m_tc, m_grant;
  assign m_tc    = init_end && ((m_n % P) == P - 1);
  assign m_grant = !m_busy && m_req && aref_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n <= 0; m_req <= 1'b0; m_busy <= 1'b0; m_k <= 0;
    end else begin
      m_n <= init_end ? m_n + 1 : 0;
      if (!init_end) m_req <= 1'b0;
      else if (m_tc) m_req <= 1'b1;
      else if (m_grant) m_req <= 1'b0;
      if (m_busy) begin
        if (m_k == END_OFF) begin m_busy <= 1'b0; m_k <= 0; end
        else m_k <= m_k + 1;
      end else if (m_grant) begin
        m_busy <= 1'b1; m_k <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("mdl_req", aref_req, m_req);
      check("mdl_cmd", aref_cmd, m_busy ? exp_cmd(m_k) : CMD_NOP);
      check("mdl_end", aref_end, m_busy && (m_k == END_OFF));
      check("mdl_bank", aref_bank_addr, 2'b11);
      check("mdl_addr", aref_addr, 13'h1fff);
    end
  end

  typedef struct {
    int         off;
    logic [3:0] cmd;
    logic       end_f;
  } vec_t;
  vec_t tbl[25];

  task automatic wait_req(output int n, input int bound);
    n = 0;
    while (!aref_req && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("req_timeout", aref_req, 1'b1);
  endtask

  task automatic run_burst(input string tag, input int hold);
    @(negedge clk) aref_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i + 1 >= hold) aref_en = 1'b0;
      if (i == 0) check({tag, "_req_clr"}, aref_req, 1'b0);
      check({tag, "_cmd"}, aref_cmd, tbl[i].cmd);
      check({tag, "_end"}, aref_end, tbl[i].end_f);
    end
    aref_en = 1'b0;
  endtask

  initial begin
    int n, r1, r2, cnt_bad, low_cnt;

    for (int i = 0; i < 25; i++) tbl[i] = '{off: i + 1, cmd: CMD_NOP, end_f: 1'b0};
    tbl[1].cmd    = CMD_PRE;
    tbl[5].cmd    = CMD_AREF;
    tbl[14].cmd   = CMD_AREF;
    tbl[22].end_f = 1'b1;

    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", aref_req, 1'b0);
    check("rst_cmd", aref_cmd, CMD_NOP);
    check("rst_end", aref_end, 1'b0);
    check("rst_bank", aref_bank_addr, 2'b11);
    check("rst_addr", aref_addr, 13'h1fff);
    #2 rst = 1'b0;

    // First request after init completes, then held with no grant.
    @(negedge clk) init_end = 1'b1;
    wait_req(n, 2000);
    check("t1_latency", n, P);
    r1 = cyc;
    repeat (2000) @(negedge clk);
    check("t3_req_held", aref_req, 1'b1);

    run_burst("t2", 25);
    wait_req(n, 2000);
    r2 = cyc;
    check("t3_rephase", (r2 - r1) % P, 0);

    // Grant dropped at T+1, then grants offered without a request.
    run_burst("t4_drop", 1);
    cnt_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      aref_en = (i < 5);
      if (aref_cmd != CMD_NOP || aref_end) cnt_bad++;
    end
    aref_en = 1'b0;
    check("t4_ignored", cnt_bad, 0);

    // Reset in the middle of a burst.
    wait_req(n, 2000);
    @(negedge clk) aref_en = 1'b1;
    @(negedge clk) aref_en = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_req", aref_req, 1'b0);
    check("t5_cmd", aref_cmd, CMD_NOP);
    check("t5_end", aref_end, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    n = 0; cnt_bad = 0;
    while (!aref_req && n < 2000) begin
      @(negedge clk);
      n++;
      if (aref_cmd != CMD_NOP || aref_end) cnt_bad++;
    end
    check("t5_latency", n, P);
    check("t5_no_residual", cnt_bad, 0);

    // init_end dropped while a request is pending.
    @(negedge clk) init_end = 1'b0;
    @(negedge clk);
    check("t6_req_drop", aref_req, 1'b0);
    cnt_bad = 0;
    for (int i = 0; i < 30; i++) begin
      aref_en = (i < 3);
      @(negedge clk);
      if (aref_cmd != CMD_NOP || aref_end) cnt_bad++;
    end
    aref_en = 1'b0;
    check("t6_grant_ignored", cnt_bad, 0);
    init_end = 1'b1;
    wait_req(n, 2000);
    check("t6_latency", n, P);

    // Random grants and occasional init_end drops, checked against the model.
    low_cnt = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (low_cnt > 0) begin
        low_cnt--;
        init_end = (low_cnt == 0);
      end else if ($urandom % 900 == 0) begin
        init_end = 1'b0;
        low_cnt = $urandom_range(1, 30);
      end
      aref_en = ($urandom % 5 == 0);
    end
    aref_en = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
